// File: rtl/ascon_pkg.sv
// Shared Ascon accelerator types: stream tags, transmit FIFO entry and keep helper.
package ascon_pkg;

    localparam int unsigned WORD_WIDTH = 64;
    localparam int unsigned WORD_BYTES = WORD_WIDTH / 8;

    typedef enum logic [3:0] {
        TUSER_RESERVED = 4'h0,
        TUSER_KEY      = 4'h1,
        TUSER_NONCE    = 4'h2,
        TUSER_AD       = 4'h3,
        TUSER_PT       = 4'h4,
        TUSER_CT       = 4'h5,
        TUSER_TAG      = 4'h6,
        TUSER_MSG      = 4'h7,
        TUSER_DIGEST   = 4'h9
    } axi_tuser_t;

    typedef struct packed {
        logic [WORD_WIDTH-1:0] data;
        logic [WORD_BYTES-1:0] keep;
        axi_tuser_t            user;
        logic                  last;
    } tx_fifo_entry_t;

    // LSB-justified byte enables; out-of-range counts map to a full word.
    function automatic logic [7:0] tkeep_from_nbytes(logic [3:0] nbytes);
        logic [7:0] keep;
        keep = 8'hFF;
        if (nbytes != 4'd0 && nbytes < 4'd8) begin
            for (int i = 0; i < 8; i++) begin
                keep[i] = (4'(i) < nbytes);
            end
        end
        return keep;
    endfunction

endpackage

// File: rtl/ascon_axis_fifo.sv
// Registered FIFO of transmit entries with registered empty and has_space flags.
module ascon_axis_fifo
    import ascon_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           flush,
    input  logic           push,
    input  tx_fifo_entry_t push_data,
    input  logic           pop,
    output tx_fifo_entry_t head,
    output logic           empty,
    output logic           has_space
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]  wr_ptr, rd_ptr, wr_n, rd_n;
    logic           wr_en, rd_en, full_n;
    tx_fifo_entry_t mem [DEPTH];

    assign wr_en = push && has_space;
    assign rd_en = pop && !empty;

    // Next pointers; the extra MSB separates full from empty on wrap.
    always_comb begin
        wr_n = wr_ptr + PW'(wr_en);
        rd_n = rd_ptr + PW'(rd_en);
        if (flush) begin
            wr_n = '0;
            rd_n = '0;
        end
        full_n = (wr_n[AW] != rd_n[AW]) && (wr_n[AW-1:0] == rd_n[AW-1:0]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            empty     <= 1'b1;
            has_space <= 1'b0;
        end else begin
            wr_ptr    <= wr_n;
            rd_ptr    <= rd_n;
            empty     <= (wr_n == rd_n);
            has_space <= !full_n;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/ascon_axis_tx.sv
// AXI4-Stream transmitter for Ascon core results: masking, framing check, FIFO.
// Optional beat/packet counters are built when ASCON_AXIS_TX_STATS_EN is defined.
module ascon_axis_tx
    import ascon_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    core_valid,
    output logic                    core_ready,
    input  logic [DATA_WIDTH-1:0]   core_data,
    input  logic [3:0]              core_nbytes,
    input  logic [3:0]              core_type,
    input  logic                    core_last,
    input  logic                    flush,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [3:0]              m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    proto_err
`ifdef ASCON_AXIS_TX_STATS_EN
    ,
    output logic [31:0]             beat_cnt,
    output logic [15:0]             pkt_cnt
`endif
);

    typedef enum logic [0:0] {IDLE, IN_PKT} tx_state_t;

    tx_state_t      state, state_n;
    axi_tuser_t     pkt_type, pkt_type_n, core_type_e;
    logic           err_n, push, pop, accept, fifo_empty;
    logic           type_ok, nb_bad, partial;
    tx_fifo_entry_t entry, head;

    assign core_type_e = axi_tuser_t'(core_type);
    assign accept      = core_valid && core_ready;
    assign pop         = m_axis_tvalid && m_axis_tready;
    assign nb_bad      = (core_nbytes == 4'd0) || (core_nbytes > 4'd8);
    assign partial     = !nb_bad && (core_nbytes < 4'd8);
    assign type_ok     = (core_type_e == TUSER_CT) || (core_type_e == TUSER_PT) ||
                         (core_type_e == TUSER_TAG) || (core_type_e == TUSER_DIGEST);

    // Bytes beyond the valid count are zeroed before buffering.
    always_comb begin
        entry      = '0;
        entry.keep = tkeep_from_nbytes(core_nbytes);
        entry.user = core_type_e;
        entry.last = core_last;
        for (int b = 0; b < int'(WORD_BYTES); b++) begin
            entry.data[b*8 +: 8] = entry.keep[b] ? core_data[b*8 +: 8] : 8'h00;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pkt_type  <= TUSER_RESERVED;
            proto_err <= 1'b0;
        end else begin
            state     <= state_n;
            pkt_type  <= pkt_type_n;
            proto_err <= err_n;
        end
    end

    // Framing: illegal types are dropped, type changes inside a packet are flagged.
    always_comb begin
        state_n    = state;
        pkt_type_n = pkt_type;
        err_n      = proto_err;
        push       = 1'b0;
        if (flush) begin
            state_n = IDLE;
            err_n   = 1'b0;
        end else if (accept) begin
            if (nb_bad || (partial && !core_last)) begin
                err_n = 1'b1;
            end
            if (!type_ok) begin
                err_n = 1'b1;
                if (core_last) begin
                    state_n = IDLE;
                end
            end else begin
                push       = 1'b1;
                pkt_type_n = core_type_e;
                if (state == IN_PKT && core_type_e != pkt_type) begin
                    err_n = 1'b1;
                end
                state_n = core_last ? IDLE : IN_PKT;
            end
        end
    end

    ascon_axis_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .push     (push),
        .push_data(entry),
        .pop      (pop),
        .head     (head),
        .empty    (fifo_empty),
        .has_space(core_ready)
    );

    assign m_axis_tvalid = !fifo_empty;
    assign m_axis_tdata  = head.data;
    assign m_axis_tkeep  = head.keep;
    assign m_axis_tuser  = head.user;
    assign m_axis_tlast  = head.last;

`ifdef ASCON_AXIS_TX_STATS_EN
    // Transfer counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt <= '0;
            pkt_cnt  <= '0;
        end else if (pop) begin
            beat_cnt <= 32'(beat_cnt + 32'd1);
            if (m_axis_tlast) begin
                pkt_cnt <= 16'(pkt_cnt + 16'd1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ascon_axis_tx.sv
// Directed self-checking bench for ascon_axis_tx.
module tb_ascon_axis_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_valid, core_ready, core_last, flush;
    logic [63:0] core_data;
    logic [3:0]  core_nbytes, core_type;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, proto_err;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic [3:0]  m_axis_tuser;
`ifdef ASCON_AXIS_TX_STATS_EN
    logic [31:0] beat_cnt;
    logic [15:0] pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    ascon_axis_tx dut (
        .clk          (clk),
        .rst          (rst),
        .core_valid   (core_valid),
        .core_ready   (core_ready),
        .core_data    (core_data),
        .core_nbytes  (core_nbytes),
        .core_type    (core_type),
        .core_last    (core_last),
        .flush        (flush),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .proto_err    (proto_err)
`ifdef ASCON_AXIS_TX_STATS_EN
        ,
        .beat_cnt     (beat_cnt),
        .pkt_cnt      (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] d, input logic [3:0] nb, input logic [3:0] ty,
                         input logic last);
        core_valid  = 1'b1;
        core_data   = d;
        core_nbytes = nb;
        core_type   = ty;
        core_last   = last;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    logic [63:0] dv [6];
    int          w, rx, leftover;

    initial begin
        rst = 1'b1; core_valid = 1'b0; core_data = '0; core_nbytes = 4'd8;
        core_type = 4'h0; core_last = 1'b0; flush = 1'b0; m_axis_tready = 1'b1;
        #1;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tdata", m_axis_tdata, 64'd0);
        check("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        check("rst_tuser", 64'(m_axis_tuser), 64'd0);
        check("rst_tlast", 64'(m_axis_tlast), 64'd0);
        check("rst_ready", 64'(core_ready), 64'd0);
        check("rst_err", 64'(proto_err), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("ready_after_rst", 64'(core_ready), 64'd1);

        // Single DIGEST word
        drive(64'h0123456789ABCDEF, 4'd8, 4'h9, 1'b1);
        tick();
        core_valid = 1'b0;
        check("dig_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("dig_tdata", m_axis_tdata, 64'h0123456789ABCDEF);
        check("dig_tkeep", 64'(m_axis_tkeep), 64'hFF);
        check("dig_tuser", 64'(m_axis_tuser), 64'h9);
        check("dig_tlast", 64'(m_axis_tlast), 64'd1);
        check("dig_err", 64'(proto_err), 64'd0);
        tick();
        check("dig_drained", 64'(m_axis_tvalid), 64'd0);

        // Three-word CT packet with partial tail
        drive(64'h1111111111111111, 4'd8, 4'h5, 1'b0);
        tick();
        check("ct1_tdata", m_axis_tdata, 64'h1111111111111111);
        check("ct1_tkeep", 64'(m_axis_tkeep), 64'hFF);
        check("ct1_tlast", 64'(m_axis_tlast), 64'd0);
        drive(64'h2222222222222222, 4'd8, 4'h5, 1'b0);
        tick();
        check("ct2_tdata", m_axis_tdata, 64'h2222222222222222);
        check("ct2_tlast", 64'(m_axis_tlast), 64'd0);
        drive(64'hFFFFFFFFFFFFFFFF, 4'd3, 4'h5, 1'b1);
        tick();
        core_valid = 1'b0;
        check("ct3_tdata", m_axis_tdata, 64'h0000000000FFFFFF);
        check("ct3_tkeep", 64'(m_axis_tkeep), 64'h07);
        check("ct3_tlast", 64'(m_axis_tlast), 64'd1);
        check("ct_err", 64'(proto_err), 64'd0);
        tick();
        check("ct_drained", 64'(m_axis_tvalid), 64'd0);

        // Backpressure: six words offered while tready=0
        for (int i = 0; i < 6; i++) dv[i] = 64'h0101010101010101 * 64'(i + 1);
        m_axis_tready = 1'b0;
        w = 0;
        drive(dv[0], 4'd8, 4'h5, 1'b0);
        repeat (4) begin
            check("bp_ready_fill", 64'(core_ready), 64'd1);
            tick();
            w++;
            core_data = dv[w];
        end
        check("bp_ready_full", 64'(core_ready), 64'd0);
        check("bp_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("bp_head", m_axis_tdata, dv[0]);
        tick(); tick();
        check("bp_hold", m_axis_tdata, dv[0]);
        check("bp_still_full", 64'(core_ready), 64'd0);
        m_axis_tready = 1'b1;
        rx = 0;
        for (int c = 0; c < 20; c++) begin
            automatic logic acc  = core_valid && core_ready;
            automatic logic xfer = m_axis_tvalid && m_axis_tready;
            if (xfer) begin
                if (rx < 6) check("bp_order", m_axis_tdata, dv[rx]);
                else        check("bp_extra_beat", 64'd1, 64'd0);
                rx++;
            end
            tick();
            if (acc) w++;
            core_valid = (w < 6);
            core_data  = (w < 6) ? dv[w] : 64'd0;
            core_last  = (w == 5);
        end
        core_valid = 1'b0;
        check("bp_rx_count", 64'(rx), 64'd6);
        check("bp_tx_count", 64'(w), 64'd6);
        check("bp_err", 64'(proto_err), 64'd0);

        // Illegal type dropped, then flush discards buffer and input
        m_axis_tready = 1'b0;
        drive(64'hDEADBEEFDEADBEEF, 4'd8, 4'h1, 1'b1);
        tick();
        core_valid = 1'b0;
        check("key_dropped", 64'(m_axis_tvalid), 64'd0);
        check("key_err", 64'(proto_err), 64'd1);
        drive(64'hAAAA, 4'd8, 4'h5, 1'b1);
        tick();
        check("pre_flush_tvalid", 64'(m_axis_tvalid), 64'd1);
        drive(64'hBBBB, 4'd8, 4'h5, 1'b1);
        pulse_flush();
        core_valid = 1'b0;
        check("flush_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("flush_err", 64'(proto_err), 64'd0);
        check("flush_ready", 64'(core_ready), 64'd1);
        tick();
        check("flush_discard", 64'(m_axis_tvalid), 64'd0);
        m_axis_tready = 1'b1;

        // CT without last followed by TAG
        drive(64'h5555, 4'd8, 4'h5, 1'b0);
        tick();
        check("cttag_b1_user", 64'(m_axis_tuser), 64'h5);
        check("cttag_b1_err", 64'(proto_err), 64'd0);
        drive(64'h6666, 4'd8, 4'h6, 1'b1);
        tick();
        core_valid = 1'b0;
        check("cttag_b2_user", 64'(m_axis_tuser), 64'h6);
        check("cttag_b2_tvalid", 64'(m_axis_tvalid), 64'd1);
        check("cttag_err", 64'(proto_err), 64'd1);
        pulse_flush();

        // CT closed by last, then TAG packet
        drive(64'h7777, 4'd8, 4'h5, 1'b1);
        tick();
        drive(64'h8888, 4'd8, 4'h6, 1'b1);
        tick();
        core_valid = 1'b0;
        check("ct_then_tag_user", 64'(m_axis_tuser), 64'h6);
        check("ct_then_tag_err", 64'(proto_err), 64'd0);
        tick();

        // nbytes=0 is a full word with an error
        drive(64'h0123456789ABCDEF, 4'd0, 4'h4, 1'b1);
        tick();
        core_valid = 1'b0;
        check("nb0_tkeep", 64'(m_axis_tkeep), 64'hFF);
        check("nb0_tdata", m_axis_tdata, 64'h0123456789ABCDEF);
        check("nb0_err", 64'(proto_err), 64'd1);
        pulse_flush();

        // Partial word not at packet end
        drive(64'hFFFFFFFFFFFFFFFF, 4'd4, 4'h4, 1'b0);
        tick();
        core_valid = 1'b0;
        check("partial_tkeep", 64'(m_axis_tkeep), 64'h0F);
        check("partial_tdata", m_axis_tdata, 64'h00000000FFFFFFFF);
        check("partial_err", 64'(proto_err), 64'd1);
        pulse_flush();

        // Reset with buffered words
        m_axis_tready = 1'b0;
        drive(64'h9999, 4'd8, 4'h5, 1'b0);
        tick();
        core_data = 64'hAAAA;
        tick();
        core_valid = 1'b0;
        check("mid_tvalid", 64'(m_axis_tvalid), 64'd1);
        rst = 1'b1;
        #1;
        check("async_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("async_rst_ready", 64'(core_ready), 64'd0);
        tick(); tick();
        rst = 1'b0;
        m_axis_tready = 1'b1;
        leftover = 0;
        repeat (5) begin
            tick();
            if (m_axis_tvalid) leftover++;
        end
        check("post_rst_beats", 64'(leftover), 64'd0);
`ifdef ASCON_AXIS_TX_STATS_EN
        check("post_rst_beat_cnt", 64'(beat_cnt), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ascon_axis_tx.md
Name: ascon_axis_tx

Overview:
- Output-side AXI4-Stream transmitter for the Ascon accelerator; the counterpart of the s_axis input parser.
- Accepts result words from the Ascon core (CT, PT, TAG, DIGEST), buffers them in a small FIFO and presents them on m_axis.
- Generates tdata, tkeep, tuser and tlast with full AXI4-Stream backpressure.
- Polices the output framing and reports a sticky protocol error.

Parameters:
- FIFO_DEPTH, 4, number of buffered words; power of two, minimum 2.
- DATA_WIDTH, 64, stream width; fixed to WORD_WIDTH; other values unsupported.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- core_valid  in  1  core presents an output word
- core_ready  out  1  transmitter can accept a word
- core_data  in  64  output word; byte 0 = bits [7:0]
- core_nbytes  in  4  valid bytes in the word, 1..8
- core_type  in  4  axi_tuser_t tag of the word
- core_last  in  1  final word of the current output packet
- flush  in  1  synchronous clear of FIFO and framing state
- m_axis_tvalid  out  1  stream valid
- m_axis_tready  in  1  stream ready
- m_axis_tdata  out  64  stream data
- m_axis_tkeep  out  8  byte enables
- m_axis_tuser  out  4  axi_tuser_t of the beat
- m_axis_tlast  out  1  packet end
- proto_err  out  1  sticky framing/type error

Behaviour:
- Reset (async, rst=1): FIFO empty, state IDLE; m_axis_tvalid=0, tdata=0, tkeep=0, tuser=TUSER_RESERVED, tlast=0; core_ready=0 while rst=1, 1 after release; proto_err=0.
- Input handshake: a word is accepted when core_valid && core_ready. core_ready = !full. Push is blocked when full even if a pop happens in the same cycle; no combinational tready-to-core_ready path.
- Output handshake: a beat is transferred when m_axis_tvalid && m_axis_tready. While tvalid=1 and tready=0, tdata/tkeep/tuser/tlast hold stable.
- Latency: a word accepted in cycle N is visible on m_axis in cycle N+1 when the FIFO was empty. Sustained throughput is 1 word/cycle when tready=1.
- tkeep: core_nbytes=n gives tkeep = (1<<n)-1, LSB-justified. Data bytes at index >= n are forced to 0.
- core_nbytes=0 or >8: word is accepted, treated as 8 bytes, proto_err set.
- Legal core_type values: TUSER_CT, TUSER_PT, TUSER_TAG, TUSER_DIGEST.
- Illegal core_type: word is accepted and dropped (not pushed); proto_err set. If core_last=1 on the dropped word, state still returns to IDLE.
- Framing FSM (evaluated on accepted words):
  - IDLE -> IN_PKT on a legal word with core_last=0; the word's type is latched as pkt_type.
  - IDLE -> IDLE on a legal word with core_last=1 (single-beat packet).
  - IN_PKT -> IN_PKT on a word with type == pkt_type and core_last=0.
  - IN_PKT -> IDLE on a word with core_last=1.
  - IN_PKT, type != pkt_type: word is still pushed, proto_err set, pkt_type updated. Exception: the CT/PT -> TAG transition is legal only when the preceding CT/PT word carried core_last=1, i.e. TAG always opens a new packet.
  - A word with nbytes<8 and core_last=0 sets proto_err (partial words only at packet end).
- m_axis_tlast = stored core_last of the beat.
- flush=1: FIFO emptied, state IDLE, m_axis_tvalid=0 on the next cycle; proto_err is cleared; any input accepted in the same cycle is discarded. Flush has priority over push and pop.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits; wrap-around uses the MSB to distinguish full from empty. A simultaneous push and pop when not full and not empty leaves the count unchanged.
- Reset asserted mid-packet: all state is lost; no partial beat is emitted after release.

Optional Feature:
- Macro ASCON_AXIS_TX_STATS_EN.
- When defined: adds outputs beat_cnt[31:0] and pkt_cnt[15:0].
  - beat_cnt increments on every m_axis transfer; pkt_cnt increments on every transfer with tlast=1.
  - Both wrap modulo 2^width, reset to 0 on rst, and are unaffected by flush.
- When undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Add to ascon_pkg: axi_tuser_t (existing); new function tkeep_from_nbytes(logic [3:0]) returning logic [7:0]; new typedef tx_fifo_entry_t as a packed struct {data 64, keep 8, user 4, last 1}.
- One natural sub-module: ascon_axis_fifo, a generic registered FIFO of tx_fifo_entry_t with full/empty flags.
- Framing FSM and masking live in ascon_axis_tx.

Test Plan:
- Single DIGEST word, data 0x0123456789ABCDEF, nbytes=8, last=1, tready=1 -> one beat next cycle: tkeep=0xFF, tuser=TUSER_DIGEST (0x9), tlast=1, proto_err=0.
- CT packet of 3 words, last word nbytes=3 data 0xFFFFFFFFFFFFFFFF -> final beat tdata=0x0000000000FFFFFF, tkeep=0x07, tlast=1; first two beats tkeep=0xFF, tlast=0.
- tready held 0 while 6 words are offered -> core_ready drops after 4 accepts; tdata stays stable; release tready -> all 4 beats emitted in order; remaining 2 accepted afterwards.
- Word with core_type=TUSER_KEY (0x1) -> nothing emitted, proto_err=1; pulse flush -> proto_err=0, FIFO empty.
- CT word with last=0, then TAG word -> both beats emitted, proto_err=1. CT with last=1, then TAG with last=1 -> proto_err stays 0.
- rst asserted with 2 words buffered and tvalid=1 -> tvalid=0 immediately (async), no beat emitted after release; with ASCON_AXIS_TX_STATS_EN, beat_cnt=0.
